// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: default element width,
// flattened-window element index and FP16 constants used by the benches.
package conv_pkg;

    localparam int unsigned CONV_DATA_WIDTH = 16;

    // FP16 encoding of 4.0
    localparam logic [15:0] FP16_FOUR = 16'h4400;

    // Index of element (row r, column c, channel d) in a flattened S x S x D window.
    function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c,
                                             input int unsigned d, input int unsigned s,
                                             input int unsigned dd);
        return (r * s + c) * dd + d;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One image row of pixels, written and read at the same column address.
// Reads are combinational, so a write in the same cycle returns the old value.
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int unsigned WIDTH = CONV_DATA_WIDTH,
    parameter int unsigned DEPTH = 28,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [0:WIDTH-1] wdata,
    output logic [0:WIDTH-1] rdata
);

    logic [0:WIDTH-1] mem [DEPTH];

    // Store the incoming pixel at its column.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_buf.sv
// Sliding S x S window generator: turns a raster pixel stream into flattened
// S x S x D windows for the convolution unit, with valid/ready on both sides.
// Optional: define CONV_WIN_COORD_EN to add win_row/win_col (window top-left).
module conv_window_buf
    import conv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = CONV_DATA_WIDTH,
    parameter int unsigned D          = 1,
    parameter int unsigned S          = 5,
    parameter int unsigned IMG_W      = 28,
    parameter int unsigned IMG_H      = 28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [0:D*DATA_WIDTH-1]       pix_in,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    output logic [0:D*S*S*DATA_WIDTH-1]   win,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic                          win_last
`ifdef CONV_WIN_COORD_EN
    ,
    output logic [$clog2(IMG_H)-1:0]      win_row,
    output logic [$clog2(IMG_W)-1:0]      win_col
`endif
);

    localparam int unsigned PW  = D * DATA_WIDTH;
    localparam int unsigned WW  = S * S * PW;
    localparam int unsigned CW  = $clog2(IMG_W);
    localparam int unsigned RW  = $clog2(IMG_H);
    localparam int unsigned NLB = S - 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(S - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(S - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [0:WW-1] win_d;
    logic          win_valid_d, win_last_d;
    logic          accept;

    logic [0:PW-1] lb_rd [NLB];
    logic [0:PW-1] lb_wd [NLB];

    // The window register is also the output stage, so it may refill as it drains.
    assign pix_ready = !win_valid || win_ready;
    assign accept    = rst && pix_valid && pix_ready;

    // Line buffer 0 holds the newest completed row; each accept ages a column by one row.
    for (genvar i = 0; i < NLB; i++) begin : g_lb
        if (i == 0) begin : g_first
            assign lb_wd[i] = pix_in;
        end else begin : g_chain
            assign lb_wd[i] = lb_rd[i-1];
        end
        conv_line_buf #(
            .WIDTH (PW),
            .DEPTH (IMG_W),
            .AW    (CW)
        ) u_line_buf (
            .clk   (clk),
            .we    (accept),
            .addr  (col_q),
            .wdata (lb_wd[i]),
            .rdata (lb_rd[i])
        );
    end

    // Next window contents, flags and raster position.
    always_comb begin
        win_d       = win;
        win_valid_d = win_valid;
        win_last_d  = win_last;
        col_d       = col_q;
        row_d       = row_q;
        if (accept) begin
            for (int unsigned r = 0; r < S; r++) begin
                for (int unsigned c = 0; c + 1 < S; c++) begin
                    win_d[(r*S+c)*PW +: PW] = win[(r*S+c+1)*PW +: PW];
                end
            end
            // Oldest row (r=0) comes from the deepest line buffer.
            for (int unsigned r = 0; r + 1 < S; r++) begin
                win_d[(r*S+S-1)*PW +: PW] = lb_rd[S-2-r];
            end
            win_d[(S*S-1)*PW +: PW] = pix_in;
            // Requiring S-1 full rows and S columns keeps stale and row-straddling data out.
            win_valid_d = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
            win_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (win_valid && win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q     <= '0;
            row_q     <= '0;
            win       <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            win       <= win_d;
            win_valid <= win_valid_d;
            win_last  <= win_last_d;
        end
    end

`ifdef CONV_WIN_COORD_EN
    // Top-left coordinate captured alongside the window; only meaningful with win_valid.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_row <= '0;
            win_col <= '0;
        end else if (accept) begin
            win_row <= row_q - ROW_FIRST;
            win_col <= col_q - COL_FIRST;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_buf.sv
// Bench for conv_window_buf on a small 4x4 frame, S=3, D=2.
module tb_conv_window_buf;
    import conv_pkg::*;

    localparam int DW = 16;
    localparam int D  = 2;
    localparam int S  = 3;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = D * DW;
    localparam int WW = S * S * PW;

    logic            clk = 1'b0;
    logic            rst;
    logic [0:PW-1]   pix_in;
    logic            pix_valid;
    logic            pix_ready;
    logic [0:WW-1]   win;
    logic            win_valid;
    logic            win_ready;
    logic            win_last;
`ifdef CONV_WIN_COORD_EN
    logic [1:0]      win_row;
    logic [1:0]      win_col;
`endif

    always #5 clk = ~clk;

    conv_window_buf #(
        .DATA_WIDTH (DW),
        .D          (D),
        .S          (S),
        .IMG_W      (W),
        .IMG_H      (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .win       (win),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .win_last  (win_last)
`ifdef CONV_WIN_COORD_EN
        ,
        .win_row   (win_row),
        .win_col   (win_col)
`endif
    );

    typedef struct {
        logic [0:WW-1] w;
        bit            last;
        int            tr;
        int            tc;
    } exp_t;

    // Golden ramp windows: channel 0 values listed in element order, channel 1 = 0x4400 + value.
    typedef struct {
        int after;
        int e0 [9];
        bit last;
        int tr;
        int tc;
    } tab_t;

    int            nvec = 0;
    int            nerr = 0;
    exp_t          expq[$];
    logic [0:PW-1] img [H][W];
    int            pos;
    int            nacc;
    int            nwin;
    int            nlast;
    int            first_last_nwin;
    tab_t          tab [4];

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [0:PW-1] ramp(input int r, input int c);
        logic [0:PW-1] p;
        p[0 +: DW]  = 16'(r * W + c);
        p[DW +: DW] = FP16_FOUR + 16'(r * W + c);
        return p;
    endfunction

    // Window with top-left (tr,tc) read straight from the stored image.
    function automatic logic [0:WW-1] build_win(input int tr, input int tc);
        logic [0:WW-1] w;
        w = '0;
        for (int r = 0; r < S; r++)
            for (int c = 0; c < S; c++)
                for (int d = 0; d < D; d++)
                    w[elem_idx(r, c, d, S, D) * DW +: DW] = img[tr+r][tc+c][d*DW +: DW];
        return w;
    endfunction

    task automatic model_accept(input logic [0:PW-1] p);
        int r;
        int c;
        exp_t e;
        r = pos / W;
        c = pos % W;
        img[r][c] = p;
        if (r >= S - 1 && c >= S - 1) begin
            e.w    = build_win(r - S + 1, c - S + 1);
            e.last = (r == H - 1) && (c == W - 1);
            e.tr   = r - S + 1;
            e.tc   = c - S + 1;
            expq.push_back(e);
        end
        pos = (pos + 1) % (W * H);
        nacc++;
    endtask

    // One clock cycle: drive at negedge, check shortly after, then update the model.
    task automatic cycle(input bit pv, input logic [0:PW-1] px, input bit wr);
        bit exp_valid;
        @(negedge clk);
        pix_valid = pv;
        pix_in    = px;
        win_ready = wr;
        #1;
        exp_valid = (expq.size() != 0);
        check("win_valid", win_valid, exp_valid);
        check("pix_ready", pix_ready, !exp_valid || wr);
        if (exp_valid) begin
            check("win", win, expq[0].w);
            check("win_last", win_last, expq[0].last);
`ifdef CONV_WIN_COORD_EN
            check("win_row", win_row, expq[0].tr);
            check("win_col", win_col, expq[0].tc);
`endif
            if (wr) begin
                nwin++;
                if (expq[0].last) begin
                    nlast++;
                    if (nlast == 1) first_last_nwin = nwin;
                end
                void'(expq.pop_front());
            end
        end
        if (pv && (!exp_valid || wr)) model_accept(px);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst       = 1'b0;
        pix_valid = 1'b1;
        pix_in    = $urandom;
        win_ready = 1'($urandom);
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        pix_valid = 1'b0;
        win_ready = 1'b0;
        expq.delete();
        pos   = 0;
        nwin  = 0;
        nlast = 0;
        first_last_nwin = 0;
        #1;
        check("rst_win_valid", win_valid, 0);
        check("rst_win_last", win_last, 0);
        check("rst_win", win, 0);
        check("rst_pix_ready", pix_ready, 1);
`ifdef CONV_WIN_COORD_EN
        check("rst_win_row", win_row, 0);
        check("rst_win_col", win_col, 0);
`endif
    endtask

    // Offer pixels until n more are accepted; random mode toggles both handshakes.
    task automatic feed(input int n, input bit rnd);
        int target;
        int b;
        logic [0:PW-1] px;
        bit pv;
        bit wr;
        target = nacc + n;
        b = 0;
        while (nacc < target && b < 600) begin
            pv = rnd ? ($urandom_range(3) != 0) : 1'b1;
            wr = rnd ? ($urandom_range(3) != 0) : 1'b1;
            px = rnd ? PW'($urandom) : ramp(pos / W, pos % W);
            cycle(pv, px, wr);
            b++;
        end
        check("feed_count", nacc, target);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (expq.size() != 0 && b < 20) begin
            cycle(1'b0, '0, 1'b1);
            b++;
        end
        check("drain_left", expq.size(), 0);
        cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [0:WW-1] tw;
        bit            found;
        int            k;

        tab[0].after = 11; tab[0].e0 = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        tab[0].last = 0;   tab[0].tr = 0; tab[0].tc = 0;
        tab[1].after = 12; tab[1].e0 = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        tab[1].last = 0;   tab[1].tr = 0; tab[1].tc = 1;
        tab[2].after = 15; tab[2].e0 = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
        tab[2].last = 0;   tab[2].tr = 1; tab[2].tc = 0;
        tab[3].after = 16; tab[3].e0 = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        tab[3].last = 1;   tab[3].tr = 1; tab[3].tc = 1;

        rst = 1'b0; pix_valid = 1'b0; win_ready = 1'b0; pix_in = '0;
        nacc = 0;

        // Unstalled ramp against the golden table, checked after every accept.
        do_reset(2);
        for (int n = 0; n < W * H; n++) begin
            cycle(1'b1, ramp(n / W, n % W), 1'b1);
            @(posedge clk);
            #1;
            found = 0;
            k = 0;
            for (int t = 0; t < 4; t++) begin
                if (tab[t].after == n + 1) begin
                    found = 1;
                    k = t;
                end
            end
            check("tab_valid", win_valid, found);
            if (found) begin
                for (int e = 0; e < S * S; e++) begin
                    tw[e*PW +: DW]      = 16'(tab[k].e0[e]);
                    tw[e*PW + DW +: DW] = FP16_FOUR + 16'(tab[k].e0[e]);
                end
                check("tab_win", win, tw);
                check("tab_last", win_last, tab[k].last);
`ifdef CONV_WIN_COORD_EN
                check("tab_row", win_row, tab[k].tr);
                check("tab_col", win_col, tab[k].tc);
`endif
            end
        end
        drain();
        check("ramp_nwin", nwin, 4);
        check("ramp_nlast", nlast, 1);

        // Consumer stalls for 5 cycles on the first window.
        do_reset(1);
        feed(11, 1'b0);
        repeat (5) cycle(1'b1, ramp(pos / W, pos % W), 1'b0);
        check("stall_pos", pos, 11);
        feed(5, 1'b0);
        drain();
        check("stall_nwin", nwin, 4);
        check("stall_nlast", nlast, 1);

        // Random handshakes over two back-to-back frames of random pixels.
        do_reset(1);
        feed(2 * W * H, 1'b1);
        drain();
        check("rand_frame1_nwin", first_last_nwin, 4);
        check("rand_nwin", nwin, 8);
        check("rand_nlast", nlast, 2);

        // Reset after 9 pixels, then a fresh full frame.
        do_reset(1);
        feed(9, 1'b0);
        do_reset(2);
        feed(W * H, 1'b0);
        drain();
        check("rstmid_nwin", nwin, 4);
        check("rstmid_nlast", nlast, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
